system_sequencer: RTL and testbench
===================================

Name: system_sequencer

Overview:
Next-generation top-level run controller for the ternary machine. It sequences program load and CPU execution, and arbitrates the single RAM port between the program loader, the CPU and a new debug port. Over the current controller it adds:
- restart from HALTED, with optional reload
- abort input
- load and execution watchdogs with a FAULT state
- execution cycle counter
It sits between cpu, program_loader and memory in the system top.

Parameters:
WORD_TRITS, 9, data word width in trits (bus width 2*WORD_TRITS bits, 2-bit trit encoding).
ADDR_TRITS, 9, memory address width in trits (bus width 2*ADDR_TRITS bits).
LOAD_LIMIT, 4096, max cycles in LOADING before fault; 0 disables.
EXEC_LIMIT, 65535, max cycles in EXECUTING before fault; 0 disables.
CNT_WIDTH, 32, width of exec_cycles and watchdog counters.

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  level input; rising edge launches a run
reload  in  1  sampled on start edge: 1 = load then execute, 0 = execute resident image
abort  in  1  forces FAULT from LOADING/EXECUTING
load_start  out  1  high while in LOADING
load_complete  in  1  loader done
loader_mem_addr  in  2*ADDR_TRITS  loader address
loader_mem_wdata  in  2*WORD_TRITS  loader write data
loader_mem_write  in  1  loader write strobe
cpu_execute  out  1  CPU run enable
cpu_restart  out  1  one-cycle pulse; CPU reinitialises PC/registers
cpu_halted  in  1  CPU executed halt
cpu_mem_addr  in  2*ADDR_TRITS  CPU address
cpu_mem_wdata  in  2*WORD_TRITS  CPU write data
cpu_mem_write  in  1  CPU write strobe
cpu_mem_read  in  1  CPU read strobe
dbg_req  in  1  debug access request
dbg_write  in  1  1 = write, 0 = read
dbg_addr  in  2*ADDR_TRITS  debug address
dbg_wdata  in  2*WORD_TRITS  debug write data
dbg_grant  out  1  debug access accepted this cycle
mem_addr  out  2*ADDR_TRITS  RAM address
mem_write_data  out  2*WORD_TRITS  RAM write data
mem_write  out  1  RAM write enable
mem_read  out  1  RAM read enable
sys_state  out  3  current state encoding
fault_code  out  2  0 none, 1 load timeout, 2 exec timeout, 3 abort
exec_cycles  out  CNT_WIDTH  cycles spent in the last or current EXECUTING

Behaviour:
- States: IDLE=0, LOADING=1, EXECUTING=2, HALTED=3, FAULT=4. Registered; all transitions on posedge clock.
- Reset values:
  - state IDLE
  - cpu_execute=0, cpu_restart=0, load_start=0
  - fault_code=0, exec_cycles=0, watchdog counter 0
  - start_prev=0, so a start held high through reset triggers exactly one run.
- start_rise = start & ~start_prev. Only edges launch runs; a held level never re-launches.
- IDLE, HALTED or FAULT, on start_rise:
  - reload=1: next state LOADING.
  - reload=0: next state EXECUTING.
  - Either way: fault_code cleared to 0.
- LOADING:
  - load_start=1.
  - Priority 1, abort: FAULT, code 3.
  - Priority 2, load_complete: EXECUTING.
  - Priority 3, watchdog reaching LOAD_LIMIT-1 (when LOAD_LIMIT≠0): FAULT, code 1.
- Entry to EXECUTING (from either source):
  - cpu_restart=1 for exactly the first EXECUTING cycle.
  - cpu_execute=1 from that same cycle.
  - exec_cycles reset to 1 on the first cycle, then increments each EXECUTING cycle, saturating at all-ones.
- EXECUTING:
  - Priority 1, abort: FAULT, code 3.
  - Priority 2, cpu_halted: HALTED.
  - Priority 3, watchdog reaching EXEC_LIMIT-1: FAULT, code 2.
  - cpu_execute drops to 0 in the first HALTED/FAULT cycle.
- Watchdog counter: cleared on every state change; counts cycles in the current state.
- In HALTED and FAULT, exec_cycles and fault_code hold.
- Memory mux (combinational on registered state):
  - LOADING: loader port; mem_read=0.
  - EXECUTING: CPU port.
  - IDLE/HALTED/FAULT: debug port; mem_write=dbg_grant&dbg_write, mem_read=dbg_grant&~dbg_write.
  - dbg_grant = dbg_req & state∈{IDLE,HALTED,FAULT}. A debug request in other states is not granted and has no memory effect.
- Read data returns from RAM directly to the requester at RAM latency; this block does not register data.
- start_rise in LOADING/EXECUTING is ignored. abort in IDLE/HALTED/FAULT is ignored.
- Reset mid-run returns to IDLE on the next edge. Outputs take reset values. A RAM write in that cycle is not issued (mem_write forced 0 while reset is high).

Decomposition:
- Package sys_seq_pkg: state encodings, fault codes, trit encoding constants.
- One combinational sub-module, mem_port_mux: 3-way select of addr/wdata/write/read by state.
- The FSM, edge detect and counters stay in system_sequencer.

Test Plan:
- Normal run: start rise with reload=1, load_complete after 10 cycles, cpu_halted after 50 EXECUTING cycles -> LOADING→EXECUTING→HALTED; cpu_restart a single pulse; exec_cycles=50; fault_code=0.
- Restart: in HALTED, start rise with reload=0 -> EXECUTING next cycle, no load_start, cpu_restart pulse, exec_cycles restarts at 1.
- Watchdog: EXEC_LIMIT=20, no halt -> FAULT after 20 EXECUTING cycles; fault_code=2; cpu_execute=0. Load timeout with LOAD_LIMIT=8 -> fault_code=1.
- Priority: abort and cpu_halted in the same cycle -> FAULT, code 3. cpu_halted on the watchdog-limit cycle -> HALTED, code 0.
- Debug: dbg_req write 0x15 to addr 4 in HALTED -> dbg_grant=1, mem_write=1; the same request in EXECUTING -> dbg_grant=0, CPU signals on the RAM port.
- Reset mid-LOADING with start held high -> IDLE, all outputs reset; one new run launches with no new edge.

Source files
------------

// File: rtl/sys_seq_pkg.sv
// Shared types for the ternary machine run sequencer:
// state and fault encodings, RAM port source select, trit constants.
package sys_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOADING   = 3'd1,
    ST_EXECUTING = 3'd2,
    ST_HALTED    = 3'd3,
    ST_FAULT     = 3'd4
  } sys_state_e;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'd0,
    FLT_LOAD_TO = 2'd1,
    FLT_EXEC_TO = 2'd2,
    FLT_ABORT   = 2'd3
  } fault_e;

  typedef enum logic [1:0] {
    SRC_DEBUG  = 2'd0,
    SRC_LOADER = 2'd1,
    SRC_CPU    = 2'd2
  } mem_src_e;

  // Balanced-ternary zero in the 2-bit trit encoding.
  localparam logic [1:0] TRIT_ZERO = 2'b00;

  function automatic mem_src_e src_of(sys_state_e s);
    mem_src_e r;
    r = SRC_DEBUG;
    unique case (s)
      ST_LOADING:   r = SRC_LOADER;
      ST_EXECUTING: r = SRC_CPU;
      default:      r = SRC_DEBUG;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/system_sequencer_mem_port_mux.sv
// Single RAM port arbitration: loader, CPU or debug
// selected purely from the registered run state.
import sys_seq_pkg::*;

module mem_port_mux #(
  parameter int WORD_TRITS = 9,
  parameter int ADDR_TRITS = 9
) (
  input  sys_state_e                  state_i,
  input  logic [2*ADDR_TRITS-1:0]     ld_addr_i,
  input  logic [2*WORD_TRITS-1:0]     ld_wdata_i,
  input  logic                        ld_write_i,
  input  logic [2*ADDR_TRITS-1:0]     cpu_addr_i,
  input  logic [2*WORD_TRITS-1:0]     cpu_wdata_i,
  input  logic                        cpu_write_i,
  input  logic                        cpu_read_i,
  input  logic                        dbg_req_i,
  input  logic                        dbg_write_i,
  input  logic [2*ADDR_TRITS-1:0]     dbg_addr_i,
  input  logic [2*WORD_TRITS-1:0]     dbg_wdata_i,
  output logic                        dbg_grant_o,
  output logic [2*ADDR_TRITS-1:0]     mem_addr_o,
  output logic [2*WORD_TRITS-1:0]     mem_wdata_o,
  output logic                        mem_write_o,
  output logic                        mem_read_o
);

  mem_src_e src;

  always_comb begin
    src         = src_of(state_i);
    dbg_grant_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = {WORD_TRITS{TRIT_ZERO}};
    mem_write_o = 1'b0;
    mem_read_o  = 1'b0;
    unique case (src)
      SRC_LOADER: begin
        mem_addr_o  = ld_addr_i;
        mem_wdata_o = ld_wdata_i;
        mem_write_o = ld_write_i;
      end
      SRC_CPU: begin
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_write_o = cpu_write_i;
        mem_read_o  = cpu_read_i;
      end
      default: begin
        dbg_grant_o = dbg_req_i;
        mem_addr_o  = dbg_addr_i;
        mem_wdata_o = dbg_wdata_i;
        mem_write_o = dbg_req_i & dbg_write_i;
        mem_read_o  = dbg_req_i & ~dbg_write_i;
      end
    endcase
  end

endmodule

// File: rtl/system_sequencer.sv
// Top-level run controller: load/execute sequencing, watchdogs,
// execution cycle counter and RAM port arbitration.
import sys_seq_pkg::*;

module system_sequencer #(
  parameter int          WORD_TRITS = 9,
  parameter int          ADDR_TRITS = 9,
  parameter int unsigned LOAD_LIMIT = 4096,
  parameter int unsigned EXEC_LIMIT = 65535,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     reload,
  input  logic                     abort,
  output logic                     load_start,
  input  logic                     load_complete,
  input  logic [2*ADDR_TRITS-1:0]  loader_mem_addr,
  input  logic [2*WORD_TRITS-1:0]  loader_mem_wdata,
  input  logic                     loader_mem_write,
  output logic                     cpu_execute,
  output logic                     cpu_restart,
  input  logic                     cpu_halted,
  input  logic [2*ADDR_TRITS-1:0]  cpu_mem_addr,
  input  logic [2*WORD_TRITS-1:0]  cpu_mem_wdata,
  input  logic                     cpu_mem_write,
  input  logic                     cpu_mem_read,
  input  logic                     dbg_req,
  input  logic                     dbg_write,
  input  logic [2*ADDR_TRITS-1:0]  dbg_addr,
  input  logic [2*WORD_TRITS-1:0]  dbg_wdata,
  output logic                     dbg_grant,
  output logic [2*ADDR_TRITS-1:0]  mem_addr,
  output logic [2*WORD_TRITS-1:0]  mem_write_data,
  output logic                     mem_write,
  output logic                     mem_read,
  output logic [2:0]               sys_state,
  output logic [1:0]               fault_code,
  output logic [CNT_WIDTH-1:0]     exec_cycles
);

  localparam logic [CNT_WIDTH-1:0] LOAD_LAST = CNT_WIDTH'(LOAD_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] EXEC_LAST = CNT_WIDTH'(EXEC_LIMIT - 1);
  localparam bit LOAD_WD_ON = (LOAD_LIMIT != 0);
  localparam bit EXEC_WD_ON = (EXEC_LIMIT != 0);

  sys_state_e           state_q, state_d;
  fault_e               fault_q, fault_d;
  logic                 start_prev_q;
  logic                 restart_q, restart_d;
  logic [CNT_WIDTH-1:0] wdog_q, wdog_d;
  logic [CNT_WIDTH-1:0] exec_q, exec_d;
  logic                 start_rise;
  logic                 load_to, exec_to;
  logic                 mux_write;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fault_q      <= FLT_NONE;
      start_prev_q <= 1'b0;
      restart_q    <= 1'b0;
      wdog_q       <= '0;
      exec_q       <= '0;
    end else begin
      state_q      <= state_d;
      fault_q      <= fault_d;
      start_prev_q <= start;
      restart_q    <= restart_d;
      wdog_q       <= wdog_d;
      exec_q       <= exec_d;
    end
  end

  always_comb begin
    start_rise = start & ~start_prev_q;
    load_to    = LOAD_WD_ON && (wdog_q == LOAD_LAST);
    exec_to    = EXEC_WD_ON && (wdog_q == EXEC_LAST);
    state_d    = state_q;
    fault_d    = fault_q;
    unique case (state_q)
      ST_IDLE, ST_HALTED, ST_FAULT: begin
        if (start_rise) begin
          state_d = reload ? ST_LOADING : ST_EXECUTING;
          fault_d = FLT_NONE;
        end
      end
      ST_LOADING: begin
        if (abort) begin
          state_d = ST_FAULT;
          fault_d = FLT_ABORT;
        end else if (load_complete) begin
          state_d = ST_EXECUTING;
        end else if (load_to) begin
          state_d = ST_FAULT;
          fault_d = FLT_LOAD_TO;
        end
      end
      ST_EXECUTING: begin
        if (abort) begin
          state_d = ST_FAULT;
          fault_d = FLT_ABORT;
        end else if (cpu_halted) begin
          state_d = ST_HALTED;
        end else if (exec_to) begin
          state_d = ST_FAULT;
          fault_d = FLT_EXEC_TO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Watchdog restarts on each state change; exec counter saturates.
  always_comb begin
    restart_d = (state_d == ST_EXECUTING) && (state_q != ST_EXECUTING);
    if (state_d != state_q)
      wdog_d = '0;
    else if (&wdog_q)
      wdog_d = wdog_q;
    else
      wdog_d = wdog_q + 1'b1;
    exec_d = exec_q;
    if (restart_d)
      exec_d = CNT_WIDTH'(1);
    else if ((state_q == ST_EXECUTING) && (state_d == ST_EXECUTING) && !(&exec_q))
      exec_d = exec_q + 1'b1;
  end

  mem_port_mux #(
    .WORD_TRITS (WORD_TRITS),
    .ADDR_TRITS (ADDR_TRITS)
  ) u_mux (
    .state_i     (state_q),
    .ld_addr_i   (loader_mem_addr),
    .ld_wdata_i  (loader_mem_wdata),
    .ld_write_i  (loader_mem_write),
    .cpu_addr_i  (cpu_mem_addr),
    .cpu_wdata_i (cpu_mem_wdata),
    .cpu_write_i (cpu_mem_write),
    .cpu_read_i  (cpu_mem_read),
    .dbg_req_i   (dbg_req),
    .dbg_write_i (dbg_write),
    .dbg_addr_i  (dbg_addr),
    .dbg_wdata_i (dbg_wdata),
    .dbg_grant_o (dbg_grant),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_write_data),
    .mem_write_o (mux_write),
    .mem_read_o  (mem_read)
  );

  // No RAM write may escape in a cycle where reset is asserted.
  assign mem_write   = mux_write & ~reset;
  assign load_start  = (state_q == ST_LOADING);
  assign cpu_execute = (state_q == ST_EXECUTING);
  assign cpu_restart = restart_q;
  assign sys_state   = state_q;
  assign fault_code  = fault_q;
  assign exec_cycles = exec_q;

endmodule

// File: tb/tb_system_sequencer.sv
// Directed bench for system_sequencer: a default instance and a
// short-watchdog instance share one stimulus stream.
module tb_system_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, reload, abort;
  logic        load_complete, loader_mem_write;
  logic [17:0] loader_mem_addr, loader_mem_wdata;
  logic        cpu_halted, cpu_mem_write, cpu_mem_read;
  logic [17:0] cpu_mem_addr, cpu_mem_wdata;
  logic        dbg_req, dbg_write;
  logic [17:0] dbg_addr, dbg_wdata;

  logic        a_load_start, a_cpu_execute, a_cpu_restart, a_dbg_grant;
  logic [17:0] a_mem_addr, a_mem_wdata;
  logic        a_mem_write, a_mem_read;
  logic [2:0]  a_state;
  logic [1:0]  a_fault;
  logic [31:0] a_cycles;

  logic        w_load_start, w_cpu_execute, w_cpu_restart, w_dbg_grant;
  logic [17:0] w_mem_addr, w_mem_wdata;
  logic        w_mem_write, w_mem_read;
  logic [2:0]  w_state;
  logic [1:0]  w_fault;
  logic [31:0] w_cycles;

  int checks = 0;
  int errors = 0;
  int rst_pulses = 0;
  int p0;

  always #5 clk = ~clk;

  always @(negedge clk) if (a_cpu_restart) rst_pulses <= rst_pulses + 1;

  system_sequencer dut_a (
    .clock(clk), .reset(reset), .start(start), .reload(reload),
    .abort(abort), .load_start(a_load_start),
    .load_complete(load_complete), .loader_mem_addr(loader_mem_addr),
    .loader_mem_wdata(loader_mem_wdata),
    .loader_mem_write(loader_mem_write),
    .cpu_execute(a_cpu_execute), .cpu_restart(a_cpu_restart),
    .cpu_halted(cpu_halted), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_write(cpu_mem_write),
    .cpu_mem_read(cpu_mem_read), .dbg_req(dbg_req),
    .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_grant(a_dbg_grant), .mem_addr(a_mem_addr),
    .mem_write_data(a_mem_wdata), .mem_write(a_mem_write),
    .mem_read(a_mem_read), .sys_state(a_state), .fault_code(a_fault),
    .exec_cycles(a_cycles)
  );

  system_sequencer #(.LOAD_LIMIT(8), .EXEC_LIMIT(20)) dut_w (
    .clock(clk), .reset(reset), .start(start), .reload(reload),
    .abort(abort), .load_start(w_load_start),
    .load_complete(load_complete), .loader_mem_addr(loader_mem_addr),
    .loader_mem_wdata(loader_mem_wdata),
    .loader_mem_write(loader_mem_write),
    .cpu_execute(w_cpu_execute), .cpu_restart(w_cpu_restart),
    .cpu_halted(cpu_halted), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_write(cpu_mem_write),
    .cpu_mem_read(cpu_mem_read), .dbg_req(dbg_req),
    .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_grant(w_dbg_grant), .mem_addr(w_mem_addr),
    .mem_write_data(w_mem_wdata), .mem_write(w_mem_write),
    .mem_read(w_mem_read), .sys_state(w_state), .fault_code(w_fault),
    .exec_cycles(w_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; start = 0; reload = 0; abort = 0;
    load_complete = 0; loader_mem_write = 0;
    loader_mem_addr = '0; loader_mem_wdata = '0;
    cpu_halted = 0; cpu_mem_write = 0; cpu_mem_read = 0;
    cpu_mem_addr = '0; cpu_mem_wdata = '0;
    dbg_req = 0; dbg_write = 0; dbg_addr = '0; dbg_wdata = '0;
    tick(); tick();

    dbg_req = 1; dbg_write = 1; #1;
    chk("rst_no_write", 32'(a_mem_write), 32'd0);
    dbg_req = 0; dbg_write = 0;
    reset = 0;
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_exec", 32'(a_cpu_execute), 32'd0);
    chk("rst_restart", 32'(a_cpu_restart), 32'd0);
    chk("rst_load", 32'(a_load_start), 32'd0);
    chk("rst_fault", 32'(a_fault), 32'd0);
    chk("rst_cycles", a_cycles, 32'd0);

    // normal run
    p0 = rst_pulses;
    start = 1; reload = 1;
    tick();
    chk("load_state", 32'(a_state), 32'd1);
    chk("load_start", 32'(a_load_start), 32'd1);
    loader_mem_addr = 18'h5; loader_mem_wdata = 18'h11;
    loader_mem_write = 1; cpu_mem_read = 1; #1;
    chk("ld_addr", 32'(a_mem_addr), 32'h5);
    chk("ld_wdata", 32'(a_mem_wdata), 32'h11);
    chk("ld_write", 32'(a_mem_write), 32'd1);
    chk("ld_read", 32'(a_mem_read), 32'd0);
    loader_mem_write = 0; cpu_mem_read = 0;
    repeat (9) tick();
    chk("load_10", 32'(a_state), 32'd1);
    load_complete = 1;
    tick();
    load_complete = 0;
    chk("exec_state", 32'(a_state), 32'd2);
    chk("exec_restart", 32'(a_cpu_restart), 32'd1);
    chk("exec_run", 32'(a_cpu_execute), 32'd1);
    chk("exec_cyc1", a_cycles, 32'd1);
    chk("exec_noload", 32'(a_load_start), 32'd0);
    tick();
    chk("restart_drop", 32'(a_cpu_restart), 32'd0);
    chk("exec_cyc2", a_cycles, 32'd2);
    repeat (48) tick();
    chk("exec_cyc50", a_cycles, 32'd50);
    cpu_halted = 1;
    tick();
    cpu_halted = 0;
    chk("halt_state", 32'(a_state), 32'd3);
    chk("halt_exec", 32'(a_cpu_execute), 32'd0);
    chk("halt_cycles", a_cycles, 32'd50);
    chk("halt_fault", 32'(a_fault), 32'd0);
    chk("one_pulse", 32'(rst_pulses - p0), 32'd1);
    tick();
    chk("held_start", 32'(a_state), 32'd3);

    // debug access in HALTED
    dbg_req = 1; dbg_write = 1; dbg_addr = 18'h4; dbg_wdata = 18'h15; #1;
    chk("dbg_grant", 32'(a_dbg_grant), 32'd1);
    chk("dbg_write", 32'(a_mem_write), 32'd1);
    chk("dbg_addr", 32'(a_mem_addr), 32'h4);
    chk("dbg_wdata", 32'(a_mem_wdata), 32'h15);
    chk("dbg_noread", 32'(a_mem_read), 32'd0);
    dbg_write = 0; #1;
    chk("dbg_read", 32'(a_mem_read), 32'd1);
    chk("dbg_rd_nowr", 32'(a_mem_write), 32'd0);
    dbg_req = 0;

    // restart without reload
    start = 0;
    tick();
    start = 1; reload = 0;
    tick();
    chk("rs_state", 32'(a_state), 32'd2);
    chk("rs_noload", 32'(a_load_start), 32'd0);
    chk("rs_restart", 32'(a_cpu_restart), 32'd1);
    chk("rs_cyc1", a_cycles, 32'd1);

    // debug request while executing
    dbg_req = 1; dbg_write = 1; dbg_addr = 18'h4; dbg_wdata = 18'h15;
    cpu_mem_addr = 18'h7; cpu_mem_wdata = 18'h2A; cpu_mem_read = 1; #1;
    chk("xd_grant", 32'(a_dbg_grant), 32'd0);
    chk("xd_addr", 32'(a_mem_addr), 32'h7);
    chk("xd_wdata", 32'(a_mem_wdata), 32'h2A);
    chk("xd_write", 32'(a_mem_write), 32'd0);
    chk("xd_read", 32'(a_mem_read), 32'd1);
    dbg_req = 0; dbg_write = 0; cpu_mem_read = 0;

    // abort beats halt
    abort = 1; cpu_halted = 1;
    tick();
    cpu_halted = 0;
    chk("ab_state", 32'(a_state), 32'd4);
    chk("ab_code", 32'(a_fault), 32'd3);
    chk("ab_exec", 32'(a_cpu_execute), 32'd0);
    chk("ab_cycles", a_cycles, 32'd1);
    tick();
    chk("ab_ignored", 32'(a_state), 32'd4);
    abort = 0;

    // exec watchdog on the short-limit instance
    reset = 1; start = 0;
    tick();
    reset = 0; start = 1; reload = 0;
    tick();
    chk("wd_exec", 32'(w_state), 32'd2);
    repeat (19) tick();
    chk("wd_c20", 32'(w_state), 32'd2);
    chk("wd_cyc20", w_cycles, 32'd20);
    tick();
    chk("wd_fault", 32'(w_state), 32'd4);
    chk("wd_code", 32'(w_fault), 32'd2);
    chk("wd_exec0", 32'(w_cpu_execute), 32'd0);
    chk("wd_cycles", w_cycles, 32'd20);
    chk("nowd_a", 32'(a_state), 32'd2);

    // halt on the limit cycle wins
    start = 0;
    tick();
    start = 1; reload = 0;
    tick();
    chk("wd2_clr", 32'(w_fault), 32'd0);
    repeat (19) tick();
    cpu_halted = 1;
    tick();
    cpu_halted = 0;
    chk("wdh_state", 32'(w_state), 32'd3);
    chk("wdh_code", 32'(w_fault), 32'd0);

    // load watchdog
    start = 0;
    tick();
    start = 1; reload = 1;
    tick();
    chk("lw_load", 32'(w_state), 32'd1);
    repeat (7) tick();
    chk("lw_c8", 32'(w_state), 32'd1);
    tick();
    chk("lw_fault", 32'(w_state), 32'd4);
    chk("lw_code", 32'(w_fault), 32'd1);
    chk("lw_noload", 32'(w_load_start), 32'd0);

    // reset mid-load with start held high
    chk("ml_load", 32'(a_state), 32'd1);
    loader_mem_write = 1; reset = 1; #1;
    chk("ml_nowrite", 32'(a_mem_write), 32'd0);
    tick();
    loader_mem_write = 0;
    chk("ml_idle", 32'(a_state), 32'd0);
    chk("ml_loadst", 32'(a_load_start), 32'd0);
    chk("ml_exec", 32'(a_cpu_execute), 32'd0);
    chk("ml_cycles", a_cycles, 32'd0);
    chk("ml_fault", 32'(a_fault), 32'd0);
    reset = 0;
    tick();
    chk("ml_relaunch", 32'(a_state), 32'd1);
    tick();
    load_complete = 1;
    tick();
    load_complete = 0;
    chk("ml_exec2", 32'(a_state), 32'd2);
    tick();
    chk("ml_once", 32'(a_cpu_restart), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
